// File: rtl/ram_4bit_div_arb.sv
// rtl/ram_4bit_div_arb.sv - two-requester round-robin arbiter and zero-fill sequencer for the division RAM
module ram_4bit_div_arb #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    async_clear_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_write_addr,
  output logic [DATA_WIDTH-1:0]   ram_data,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic                    last_grant;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [1:0]              grant;
  logic                    sel;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Grant is gated by reset so handshakes cannot occur while async_clear_n is low.
  always_comb begin
    grant = 2'b00;
    if (async_clear_n && state == RUN && !clr_start) begin
      if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  assign sel       = grant[1];
  assign sel_we    = req_we[sel];
  assign sel_addr  = sel ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
  assign sel_wdata = sel ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];

  assign req_ready = grant;
  assign clr_busy  = (state == CLEAR);
  assign rsp_data  = ram_q;

  always_comb begin
    state_nxt      = state;
    ram_we         = 1'b0;
    ram_write_addr = '0;
    ram_data       = '0;
    ram_read_addr  = rd_addr_q;
    case (state)
      RUN: begin
        if (async_clear_n && clr_start) state_nxt = CLEAR;
        if (grant != 2'b00) begin
          if (sel_we) begin
            ram_we         = 1'b1;
            ram_write_addr = sel_addr;
            ram_data       = sel_wdata;
          end else begin
            ram_read_addr  = sel_addr;
          end
        end
      end
      CLEAR: begin
        ram_we         = 1'b1;
        ram_write_addr = clr_cnt;
        if (clr_cnt == LAST_ADDR) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      state      <= RUN;
      last_grant <= 1'b1;
      clr_cnt    <= '0;
      rd_addr_q  <= '0;
      rsp_valid  <= 2'b00;
      clr_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr_q <= ram_read_addr;
      rsp_valid <= grant & ~req_we;
      clr_done  <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
      if (grant != 2'b00) last_grant <= grant[1];
      // Counter returns to 0 when the sweep exits so the next sweep starts at address 0.
      if (state == CLEAR) begin
        if (clr_cnt == LAST_ADDR) clr_cnt <= '0;
        else                      clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_4bit_div_arb.sv
// tb/tb_ram_4bit_div_arb.sv - scoreboard bench for ram_4bit_div_arb with a behavioural RAM
module tb_ram_4bit_div_arb;
  localparam int DW    = 4;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             async_clear_n;
  logic [1:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [2*AW-1:0]  req_addr;
  logic [2*DW-1:0]  req_wdata;
  logic [DW-1:0]    rsp_data;
  logic             clr_start, clr_busy, clr_done, ram_we;
  logic [AW-1:0]    ram_write_addr, ram_read_addr;
  logic [DW-1:0]    ram_data;
  logic [DW-1:0]    ram_q = '0;

  ram_4bit_div_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .async_clear_n(async_clear_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  // Synchronous-read RAM standing in for the division RAM.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_write_addr] <= ram_data;
    ram_q <= ram_mem[ram_read_addr];
  end

  typedef struct {int who; logic [DW-1:0] data; bit chk; int due;} rsp_t;
  rsp_t sb[$];

  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  bit            pend [2];
  bit            pwe  [2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pdata[2];
  int  last_g = 1;
  int  sweep_left = 0;
  bit  done_next = 1'b0;
  bit  clr_req = 1'b0;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  logic [1:0] last_ready;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (async_clear_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rsp_valid", {30'd0, rsp_valid}, (e.who == 1) ? 32'd2 : 32'd1);
        if (e.chk) check("rsp_data", {28'd0, rsp_data}, {28'd0, e.data});
      end else if (rsp_valid != 2'b00) begin
        check("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
      end
    end
  end

  task automatic apply();
    req_valid = {pend[1], pend[0]};
    req_we    = {pwe[1], pwe[0]};
    req_addr  = {paddr[1], paddr[0]};
    req_wdata = {pdata[1], pdata[0]};
    clr_start = clr_req;
  endtask

  // One clock cycle: entered and left just after a rising edge.
  task automatic tick();
    logic [1:0] eg;
    int wa;
    int g;
    eg = 2'b00;
    wa = 0;
    apply();
    @(negedge clk);
    if (sweep_left > 0) begin
      wa = DEPTH - sweep_left;
      check("clr_busy", {31'd0, clr_busy}, 32'd1);
      check("clr_done_in_sweep", {31'd0, clr_done}, 32'd0);
      check("ready_in_sweep", {30'd0, req_ready}, 32'd0);
      check("ram_we_in_sweep", {31'd0, ram_we}, 32'd1);
      check("clr_addr", {25'd0, ram_write_addr}, wa);
      check("clr_data", {28'd0, ram_data}, 32'd0);
    end else begin
      check("clr_busy", {31'd0, clr_busy}, 32'd0);
      check("clr_done", {31'd0, clr_done}, {31'd0, done_next});
      done_next = 1'b0;
      if (!clr_req) begin
        if (pend[0] && pend[1]) eg = (last_g == 0) ? 2'b10 : 2'b01;
        else                    eg = {pend[1], pend[0]};
      end
      check("req_ready", {30'd0, req_ready}, {30'd0, eg});
    end
    last_ready = req_ready;
    if (sweep_left > 0) begin
      ref_mem[wa] = '0;
      known[wa]   = 1'b1;
      sweep_left--;
      if (sweep_left == 0) done_next = 1'b1;
    end else if (clr_req) begin
      sweep_left = DEPTH;
    end else if (eg != 2'b00) begin
      g = eg[1] ? 1 : 0;
      last_g = g;
      if (pwe[g]) begin
        ref_mem[paddr[g]] = pdata[g];
        known[paddr[g]]   = 1'b1;
      end else begin
        sb.push_back('{g, ref_mem[paddr[g]], known[paddr[g]], cyc + 1});
      end
      pend[g] = 1'b0;
    end
    clr_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    async_clear_n = 1'b0;
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("rst_clr_done", {31'd0, clr_done}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_write_addr", {25'd0, ram_write_addr}, 32'd0);
    check("rst_ram_read_addr", {25'd0, ram_read_addr}, 32'd0);
    check("rst_ram_data", {28'd0, ram_data}, 32'd0);
    sb.delete();
    sweep_left = 0;
    done_next  = 1'b0;
    last_g     = 1;
    clr_req    = 1'b0;
    apply();
    @(posedge clk);
    #1;
    async_clear_n = 1'b1;
  endtask

  task automatic serve(input int i);
    for (int k = 0; k < 10 && pend[i]; k++) tick();
    if (pend[i]) check("serve_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input int i, input bit we, input int addr, input int data);
    serve(i);
    pend[i]  = 1'b1;
    pwe[i]   = we;
    paddr[i] = AW'(addr);
    pdata[i] = DW'(data);
    serve(i);
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 6) begin
          pend[i]  = 1'b1;
          pwe[i]   = 1'($urandom_range(0, 1));
          paddr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                 : AW'($urandom_range(0, 7));
          pdata[i] = DW'($urandom);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known[i]   = 1'b0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b1; pwe[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    async_clear_n = 1'b1;
    apply();
    #2;
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Write then read from the other requester.
    issue(0, 1'b1, 5, 4'hA);
    issue(1, 1'b0, 5, 0);
    tick();

    // Continuous contention alternates grants starting with requester 0.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin pend[i] = 1'b1; pwe[i] = 1'b0; paddr[i] = AW'(k + i); end
      end
      tick();
      check("rr_seq", {30'd0, last_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    serve(0);
    serve(1);

    random_phase(200);
    serve(0);
    serve(1);

    issue(0, 1'b1, 5, 4'h7);
    issue(1, 1'b1, 127, 4'hF);
    issue(0, 1'b1, 33, 4'h9);

    // Read just before clr_start, then sweep with both requests pending.
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 7'd33;
    tick();
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 7'd5;
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 7'd127;
    clr_req = 1'b1;
    tick();
    for (int k = 0; k < DEPTH; k++) tick();
    tick();
    serve(0);
    serve(1);
    tick();

    // Second sweep with a stray clr_start mid-sweep.
    clr_req = 1'b1;
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 60) clr_req = 1'b1;
      tick();
    end
    tick();
    tick();

    random_phase(150);
    serve(0);
    serve(1);

    // Reset at clr_cnt = 40 leaves unswept addresses intact.
    issue(0, 1'b1, 100, 4'h3);
    issue(1, 1'b1, 41, 4'hC);
    clr_req = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) tick();
    do_reset();
    issue(0, 1'b0, 100, 0);
    issue(1, 1'b0, 39, 0);
    issue(0, 1'b0, 41, 0);
    tick();

    random_phase(100);
    serve(0);
    serve(1);
    tick();
    tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
